// File: rtl/switch_entry_sequencer.sv
// Switch entry sequencer: debounced ENTER/COMMIT keys assemble a WIDTH-bit word from
// nibbles and write it to a register file over req/ack. Optional macro: SEQ_ADDR_AUTOINC_EN.
module switch_entry_sequencer #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 5,
    parameter int DEBOUNCE = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    sw_nibble,
    input  logic [ADDR_W-1:0]             sw_addr,
    input  logic                          key_enter,
    input  logic                          key_commit,
    output logic                          wr_req,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [WIDTH-1:0]              wr_data,
    input  logic                          wr_ack,
    output logic [WIDTH-1:0]              word_preview,
    output logic [$clog2(WIDTH/4):0]      nib_cnt,
    output logic                          full,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    dbg_state
);

    localparam int NC_W  = $clog2(WIDTH/4) + 1;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int NIB_N = WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REQ     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Handshake: wr_req rises the cycle after COMMIT is accepted and stays high with
    // wr_addr/wr_data frozen until wr_ack is sampled high; wr_ack is ignored otherwise.

    logic [1:0] key_raw;
    logic [1:0] key_lvl;
    logic [1:0] key_ev;

    assign key_raw = {key_commit, key_enter};

    // Index 0 is ENTER, index 1 is COMMIT.
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic            s1_q, s2_q;
        logic            lvl_q, lvl_d;
        logic            ev_q, ev_d;
        logic [DB_W-1:0] cnt_q, cnt_d;

        always_comb begin
            lvl_d = lvl_q;
            ev_d  = 1'b0;
            cnt_d = '0;
            if (s2_q != lvl_q) begin
                if (cnt_q == DB_W'(DEBOUNCE - 1)) begin
                    lvl_d = s2_q;
                    ev_d  = s2_q;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                lvl_q <= 1'b0;
                ev_q  <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q  <= key_raw[k];
                s2_q  <= s1_q;
                lvl_q <= lvl_d;
                ev_q  <= ev_d;
                cnt_q <= cnt_d;
            end
        end

        assign key_lvl[k] = lvl_q;
        assign key_ev[k]  = ev_q;
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [NC_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic              full_w;

    assign full_w = (nib_cnt_q == NC_W'(NIB_N));

`ifdef SEQ_ADDR_AUTOINC_EN
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt_q <= '0;
        end else begin
            addr_cnt_q <= addr_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        nib_cnt_d = nib_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef SEQ_ADDR_AUTOINC_EN
        addr_cnt_d = addr_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_COLLECT: begin
                // COMMIT has priority; a coincident ENTER event is discarded.
                if (key_ev[1]) begin
`ifdef SEQ_ADDR_AUTOINC_EN
                    if (key_lvl[0]) begin
                        addr_cnt_d = sw_addr;
                    end else if (state_q == S_COLLECT) begin
                        wr_addr_d = addr_cnt_q;
                        wr_data_d = word_q;
                        state_d   = S_REQ;
                    end
`else
                    if (state_q == S_COLLECT) begin
                        wr_addr_d = sw_addr;
                        wr_data_d = word_q;
                        state_d   = S_REQ;
                    end
`endif
                end else if (key_ev[0] && !full_w) begin
                    word_d    = (word_q << 4) | WIDTH'(sw_nibble);
                    nib_cnt_d = nib_cnt_q + NC_W'(1);
                    state_d   = S_COLLECT;
                end
            end
            S_REQ: begin
                if (wr_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                word_d    = '0;
                nib_cnt_d = '0;
                state_d   = S_IDLE;
`ifdef SEQ_ADDR_AUTOINC_EN
                addr_cnt_d = addr_cnt_q + ADDR_W'(1);
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            nib_cnt_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            nib_cnt_q <= nib_cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_req       = (state_q == S_REQ);
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign word_preview = word_q;
    assign nib_cnt      = nib_cnt_q;
    assign full         = full_w;
    assign busy         = (state_q == S_REQ) || (state_q == S_DONE);
    assign done         = (state_q == S_DONE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_switch_entry_sequencer.sv
// Bench for switch_entry_sequencer: random key/nibble stimulus, a nibble-list reference
// model, and a write scoreboard popped by an independent monitor.
module tb_switch_entry_sequencer;

  localparam int WIDTH    = 16;
  localparam int ADDR_W   = 5;
  localparam int DEBOUNCE = 4;
  localparam int NIB_N    = WIDTH / 4;
  localparam int NC_W     = $clog2(WIDTH / 4) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]        sw_nibble = '0;
  logic [ADDR_W-1:0] sw_addr = '0;
  logic              key_enter = 1'b0;
  logic              key_commit = 1'b0;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_ack;
  logic [WIDTH-1:0]  word_preview;
  logic [NC_W-1:0]   nib_cnt;
  logic              full;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  switch_entry_sequencer #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .reset(reset), .sw_nibble(sw_nibble), .sw_addr(sw_addr),
    .key_enter(key_enter), .key_commit(key_commit), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .word_preview(word_preview), .nib_cnt(nib_cnt), .full(full),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;

  // scoreboard: {addr, data} of every write the model expects
  logic [ADDR_W+WIDTH-1:0] exp_q[$];
  logic [3:0]              model_nibs[$];
  logic [ADDR_W-1:0]       model_acnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_word();
    logic [WIDTH-1:0] w;
    w = '0;
    foreach (model_nibs[i]) w = w * 16 + WIDTH'(model_nibs[i]);
    return w;
  endfunction

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cyc(n);
    reset = 1'b0;
    model_nibs.delete();
    model_acnt = '0;
  endtask

  task automatic model_enter(input logic [3:0] nib, input bit dropped);
    if (!dropped && model_nibs.size() < NIB_N) model_nibs.push_back(nib);
  endtask

  task automatic model_commit(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] a;
    if (model_nibs.size() == 0) return;
`ifdef SEQ_ADDR_AUTOINC_EN
    a = model_acnt;
    model_acnt = model_acnt + 1'b1;
`else
    a = addr;
`endif
    exp_q.push_back({a, model_word()});
    model_nibs.delete();
  endtask

  task automatic check_entry(input string tag);
    check({tag, ".nib_cnt"}, 64'(nib_cnt), 64'(model_nibs.size()));
    check({tag, ".preview"}, 64'(word_preview), 64'(model_word()));
    check({tag, ".full"}, 64'(full), 64'(model_nibs.size() == NIB_N));
  endtask

  task automatic press_enter(input logic [3:0] nib, input bit dropped);
    model_enter(nib, dropped);
    sw_nibble = nib;
    key_enter = 1'b1;
    cyc(10);
    key_enter = 1'b0;
    cyc(10);
  endtask

  task automatic press_commit(input logic [ADDR_W-1:0] addr);
    model_commit(addr);
    sw_addr = addr;
    key_commit = 1'b1;
    cyc(10);
    key_commit = 1'b0;
    cyc(10);
  endtask

  task automatic press_both(input logic [3:0] nib, input logic [ADDR_W-1:0] addr);
`ifdef SEQ_ADDR_AUTOINC_EN
    model_acnt = addr;
`else
    model_commit(addr);
`endif
    sw_nibble = nib;
    sw_addr = addr;
    key_enter = 1'b1;
    key_commit = 1'b1;
    cyc(10);
    key_enter = 1'b0;
    key_commit = 1'b0;
    cyc(10);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || wr_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".idle_timeout"}, 64'(n < 300), 64'(1));
  endtask

  // register-file responder
  initial begin
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req) begin
        repeat (ack_delay) @(negedge clk);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
      end
    end
  end

  // monitor: pops scoreboard on each new request, checks hold and done timing
  initial begin
    logic                    prev_req;
    logic                    prev_acked;
    logic [ADDR_W+WIDTH-1:0] held;
    logic [ADDR_W+WIDTH-1:0] e;
    prev_req = 1'b0;
    prev_acked = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      check("done_pulse", 64'(done), 64'(prev_acked));
      if (wr_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e[ADDR_W+WIDTH-1:WIDTH]));
          check("wr_data", 64'(wr_data), 64'(e[WIDTH-1:0]));
        end
        held = {wr_addr, wr_data};
      end else if (wr_req) begin
        check("wr_hold", 64'({wr_addr, wr_data}), 64'(held));
      end
      prev_acked = wr_req && wr_ack && !reset;
      prev_req = wr_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int n;
    int lat;
    do_reset(3);
    @(negedge clk);
    check("rst.wr_req", 64'(wr_req), 64'(0));
    check("rst.wr_addr", 64'(wr_addr), 64'(0));
    check("rst.wr_data", 64'(wr_data), 64'(0));
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check_entry("rst");

    // commit with no nibbles
    press_commit(5'd3);
    cyc(5);
    check("idle_commit.busy", 64'(busy), 64'(0));
    check_entry("idle_commit");

    // glitches shorter than the debounce window
    sw_nibble = 4'h9;
    for (int i = 0; i < 6; i++) begin
      key_enter = 1'b1;
      cyc(1);
      key_enter = 1'b0;
      cyc(3);
    end
    cyc(10);
    check_entry("glitch");

    // clean press: capture 2 sync + DEBOUNCE + 1 capture cycle after the press
    sw_nibble = 4'h5;
    key_enter = 1'b1;
    lat = 0;
    while (nib_cnt == 0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("enter_latency", 64'(lat), 64'(DEBOUNCE + 3));
    model_enter(4'h5, 1'b0);
    cyc(10);
    key_enter = 1'b0;
    cyc(10);
    check_entry("clean");

    // A,B,C,D then overflow F, commit to 7 with delayed ack
    do_reset(3);
    press_enter(4'hA, 1'b0);
    press_enter(4'hB, 1'b0);
    press_enter(4'hC, 1'b0);
    press_enter(4'hD, 1'b0);
    check_entry("abcd");
    press_enter(4'hF, 1'b0);
    check_entry("overflow");
    ack_delay = 5;
    press_commit(5'd7);
    wait_idle("abcd");
    check_entry("abcd_done");

    // ENTER during a long request is dropped
    press_enter(4'h3, 1'b0);
    ack_delay = 40;
    press_commit(5'd9);
    press_enter(4'h4, 1'b1);
    wait_idle("req_drop");
    cyc(2);
    check_entry("req_drop");

    // ENTER and COMMIT events in the same cycle
    ack_delay = 2;
    press_enter(4'h1, 1'b0);
    press_enter(4'h2, 1'b0);
    press_both(4'h3, 5'd12);
    wait_idle("both");
`ifdef SEQ_ADDR_AUTOINC_EN
    check_entry("both_load");
    press_commit(5'd0);
    wait_idle("both_commit");
`endif
    check_entry("both");

`ifdef SEQ_ADDR_AUTOINC_EN
    // load counter to 31 with ENTER held, then two writes wrap 31 -> 0
    sw_nibble = 4'h1;
    model_enter(4'h1, 1'b0);
    key_enter = 1'b1;
    cyc(10);
    sw_addr = 5'd31;
    key_commit = 1'b1;
    model_acnt = 5'd31;
    cyc(10);
    key_commit = 1'b0;
    key_enter = 1'b0;
    cyc(10);
    check_entry("load");
    press_commit(5'd3);
    wait_idle("wrap1");
    press_enter(4'h2, 1'b0);
    press_commit(5'd9);
    wait_idle("wrap2");
`endif

    // randomized entry/commit sequences
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) press_enter(4'($urandom_range(0, 15)), 1'b0);
      check_entry("rand_entry");
      ack_delay = $urandom_range(0, 6);
      press_commit(ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)));
      wait_idle("rand");
      cyc(2);
      check_entry("rand_done");
    end

    // reset while a request is outstanding
    press_enter(4'h6, 1'b0);
    ack_delay = 40;
    model_commit(5'd4);
    sw_addr = 5'd4;
    key_commit = 1'b1;
    n = 0;
    while (!wr_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_req.reached", 64'(wr_req), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_nibs.delete();
    model_acnt = '0;
    check("rst_req.wr_req", 64'(wr_req), 64'(0));
    check("rst_req.busy", 64'(busy), 64'(0));
    key_commit = 1'b0;
    cyc(60);
    check_entry("rst_req");

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
